multi_players: RTL and testbench



---
 rtl/multi_players.sv | 100 ++++++++++
 tb/tb_multi_players.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_players.sv
// Paddle overlay stage: draws NUM_PLY paddles into the 26-bit RGB pixel stream.
// One pixel-clock register stage; positions and enables are shadowed at each vsync rising edge.
module multi_players #(
   parameter int                    NUM_PLY    = 2,
   parameter logic [NUM_PLY-1:0]    PLY_TYPE   = '0,
   parameter logic [10*NUM_PLY-1:0] PLY_OFFSET = {10'd770, 10'd20},
   parameter logic [3*NUM_PLY-1:0]  PLY_COLOR  = {3'b111, 3'b111},
   parameter int                    PLY_LEN    = 64,
   parameter int                    PLY_THICK  = 8,
   parameter int                    POS_MAX    = 479
) (
   input  logic                    px_clk,
   input  logic                    reset,
   input  logic [25:0]             strRGB_i,
   input  logic [10*NUM_PLY-1:0]   pos_i,
   input  logic [NUM_PLY-1:0]      ply_en,
   output logic [25:0]             strRGB_o,
   output logic                    frame_tick
);

   localparam logic [10:0] LIMIT   = 11'(POS_MAX - PLY_LEN + 1);
   localparam logic [10:0] LEN11   = 11'(PLY_LEN);
   localparam logic [10:0] THICK11 = 11'(PLY_THICK);

   logic [9:0]         r_pos [NUM_PLY];
   logic [NUM_PLY-1:0] r_en;
   logic               r_vsync_d;

   logic [10:0]        w_x;
   logic [10:0]        w_y;
   logic               w_active;
   logic               w_vs_rise;
   logic [9:0]         w_clamped [NUM_PLY];
   logic [NUM_PLY-1:0] w_hit;
   logic [2:0]         w_rgb;

   // 11-bit zero-extended coordinates keep offset+thickness and pos+length from wrapping at 1023
   assign w_x       = {1'b0, strRGB_i[25:16]};
   assign w_y       = {1'b0, strRGB_i[15:6]};
   assign w_active  = strRGB_i[5];
   assign w_vs_rise = strRGB_i[3] & ~r_vsync_d;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLY; gi++) begin : g_ply
         logic [9:0]  w_pos_in;
         logic [10:0] w_off;
         logic [10:0] w_fix;
         logic [10:0] w_mov;
         logic [10:0] w_start;
         logic        w_in_fix;
         logic        w_in_mov;

         assign w_pos_in       = pos_i[10*gi +: 10];
         assign w_clamped[gi]  = ({1'b0, w_pos_in} > LIMIT) ? LIMIT[9:0] : w_pos_in;

         assign w_off   = {1'b0, PLY_OFFSET[10*gi +: 10]};
         assign w_start = {1'b0, r_pos[gi]};
         assign w_fix   = PLY_TYPE[gi] ? w_y : w_x;
         assign w_mov   = PLY_TYPE[gi] ? w_x : w_y;

         assign w_in_fix  = (w_fix >= w_off)   && (w_fix < w_off + THICK11);
         assign w_in_mov  = (w_mov >= w_start) && (w_mov < w_start + LEN11);
         assign w_hit[gi] = w_in_fix && w_in_mov && r_en[gi] && w_active;
      end
   endgenerate

   // Walk from highest to lowest index so the lowest-index hitting paddle wins
   always_comb begin
      w_rgb = strRGB_i[2:0];
      for (int k = NUM_PLY - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            w_rgb = PLY_COLOR[3*k +: 3];
         end
      end
   end

   always_ff @(posedge px_clk) begin
      if (reset) begin
         strRGB_o   <= '0;
         frame_tick <= 1'b0;
         r_vsync_d  <= 1'b0;
         r_en       <= '0;
         for (int k = 0; k < NUM_PLY; k++) begin
            r_pos[k] <= '0;
         end
      end else begin
         strRGB_o   <= {strRGB_i[25:3], w_rgb};
         frame_tick <= w_vs_rise;
         r_vsync_d  <= strRGB_i[3];
         if (w_vs_rise) begin
            r_en <= ply_en;
            for (int k = 0; k < NUM_PLY; k++) begin
               r_pos[k] <= w_clamped[k];
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_players.sv
// Directed bench for multi_players: a default 2-paddle instance and a 3-paddle
// instance with a horizontal paddle that overlaps a vertical one.
module tb_multi_players;

   logic        px_clk = 1'b0;
   logic        reset;
   logic [25:0] in2, out2, in3, out3;
   logic [19:0] pos2;
   logic [1:0]  en2;
   logic [29:0] pos3;
   logic [2:0]  en3;
   logic        tick2, tick3;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 px_clk = ~px_clk;

   multi_players dut2 (
      .px_clk(px_clk), .reset(reset), .strRGB_i(in2), .pos_i(pos2),
      .ply_en(en2), .strRGB_o(out2), .frame_tick(tick2)
   );

   multi_players #(
      .NUM_PLY(3),
      .PLY_TYPE(3'b100),
      .PLY_OFFSET({10'd400, 10'd770, 10'd300}),
      .PLY_COLOR({3'b001, 3'b010, 3'b100})
   ) dut3 (
      .px_clk(px_clk), .reset(reset), .strRGB_i(in3), .pos_i(pos3),
      .ply_en(en3), .strRGB_o(out3), .frame_tick(tick3)
   );

   function automatic logic [25:0] px(input int x, input int y, input logic act,
                                      input logic hs, input logic vs, input logic [2:0] rgb);
      return {x[9:0], y[9:0], act, hs, vs, rgb};
   endfunction

   task automatic step();
      @(posedge px_clk);
      #1;
   endtask

   task automatic latch2(input logic [19:0] p, input logic [1:0] e);
      in2 = px(0, 0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      pos2 = p;
      en2  = e;
      in2  = px(0, 0, 1'b0, 1'b0, 1'b1, 3'b000);
      step();
      in2  = px(0, 0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic latch3(input logic [29:0] p, input logic [2:0] e);
      in3 = px(0, 0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      pos3 = p;
      en3  = e;
      in3  = px(0, 0, 1'b0, 1'b0, 1'b1, 3'b000);
      step();
      in3  = px(0, 0, 1'b0, 1'b0, 1'b0, 3'b000);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      pos2  = {10'd100, 10'd100};
      en2   = 2'b11;
      in2   = px(20, 100, 1'b1, 1'b1, 1'b1, 3'b101);
      in3   = px(20, 100, 1'b1, 1'b1, 1'b1, 3'b101);
      step();
      n_tests++;
      if (out2 !== 26'd0 || tick2 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut2: got out=%h tick=%b, expected out=0 tick=0", out2, tick2);
      end
      n_tests++;
      if (out3 !== 26'd0 || tick3 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_dut3: got out=%h tick=%b, expected out=0 tick=0", out3, tick3);
      end
      // vsync still high on the first post-reset cycle counts as an edge
      reset = 1'b0;
      step();
      n_tests++;
      if (tick2 !== 1'b1 || out2 !== px(20, 100, 1'b1, 1'b1, 1'b1, 3'b101)) begin
         n_fail++;
         $display("FAIL reset_vsync_high_latch: got out=%h tick=%b, expected out=%h tick=1",
                  out2, tick2, px(20, 100, 1'b1, 1'b1, 1'b1, 3'b101));
      end
      in2 = px(20, 100, 1'b1, 1'b0, 1'b1, 3'b000);
      step();
      n_tests++;
      if (tick2 !== 1'b0 || out2 !== px(20, 100, 1'b1, 1'b0, 1'b1, 3'b111)) begin
         n_fail++;
         $display("FAIL reset_vsync_high_draw: got out=%h tick=%b, expected out=%h tick=0",
                  out2, tick2, px(20, 100, 1'b1, 1'b0, 1'b1, 3'b111));
      end
   endtask

   task automatic test_no_vsync();
      int         tx[4] = '{20, 24, 770, 0};
      int         ty[4] = '{200, 230, 100, 0};
      logic [2:0] tc[4] = '{3'b010, 3'b110, 3'b001, 3'b000};
      logic [25:0] exp_w;
      reset = 1'b1;
      in2   = px(0, 0, 1'b0, 1'b0, 1'b0, 3'b000);
      step();
      reset = 1'b0;
      pos2  = {10'd100, 10'd200};
      en2   = 2'b11;
      for (int i = 0; i < 4; i++) begin
         in2 = px(tx[i], ty[i], 1'b1, i[0], 1'b0, tc[i]);
         step();
         exp_w = px(tx[i], ty[i], 1'b1, i[0], 1'b0, tc[i]);
         n_tests++;
         if (out2 !== exp_w || tick2 !== 1'b0) begin
            n_fail++;
            $display("FAIL no_vsync[%0d]: got out=%h tick=%b, expected out=%h tick=0",
                     i, out2, tick2, exp_w);
         end
      end
   endtask

   task automatic test_basic();
      int         tx[10] = '{20, 27, 28, 20, 19, 20, 770, 777, 778, 769};
      int         ty[10] = '{200, 263, 200, 264, 200, 199, 200, 263, 200, 263};
      logic [2:0] tc[10] = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b000,
                             3'b000, 3'b111, 3'b111, 3'b000, 3'b000};
      logic [25:0] exp_w;
      latch2({10'd200, 10'd200}, 2'b11);
      n_tests++;
      if (tick2 !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_tick_high: got %b, expected 1", tick2);
      end
      for (int i = 0; i < 10; i++) begin
         in2 = px(tx[i], ty[i], 1'b1, 1'b0, 1'b0, 3'b000);
         step();
         exp_w = px(tx[i], ty[i], 1'b1, 1'b0, 1'b0, tc[i]);
         n_tests++;
         if (out2 !== exp_w || tick2 !== 1'b0) begin
            n_fail++;
            $display("FAIL basic[%0d] (%0d,%0d): got out=%h tick=%b, expected out=%h tick=0",
                     i, tx[i], ty[i], out2, tick2, exp_w);
         end
      end
   endtask

   task automatic test_clamp();
      int         ax[7] = '{20, 20, 20, 770, 770, 20, 20};
      int         ay[7] = '{416, 415, 479, 416, 415, 50, 113};
      logic [2:0] ac[7] = '{3'b111, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 3'b000};
      int         bx[4] = '{20, 20, 20, 20};
      int         by[4] = '{50, 416, 113, 114};
      logic [2:0] bc[4] = '{3'b111, 3'b000, 3'b111, 3'b000};
      logic [25:0] exp_w;
      latch2({10'd1000, 10'd470}, 2'b11);
      // mid-frame request change must stay invisible
      pos2 = {10'd50, 10'd50};
      for (int i = 0; i < 7; i++) begin
         in2 = px(ax[i], ay[i], 1'b1, 1'b0, 1'b0, 3'b000);
         step();
         exp_w = px(ax[i], ay[i], 1'b1, 1'b0, 1'b0, ac[i]);
         n_tests++;
         if (out2 !== exp_w) begin
            n_fail++;
            $display("FAIL clamp[%0d] (%0d,%0d): got %h, expected %h", i, ax[i], ay[i], out2, exp_w);
         end
      end
      latch2({10'd50, 10'd50}, 2'b11);
      for (int i = 0; i < 4; i++) begin
         in2 = px(bx[i], by[i], 1'b1, 1'b0, 1'b0, 3'b000);
         step();
         exp_w = px(bx[i], by[i], 1'b1, 1'b0, 1'b0, bc[i]);
         n_tests++;
         if (out2 !== exp_w) begin
            n_fail++;
            $display("FAIL relatch[%0d] (%0d,%0d): got %h, expected %h", i, bx[i], by[i], out2, exp_w);
         end
      end
   endtask

   task automatic test_priority();
      int         ax[6] = '{300, 307, 300, 363, 364, 770};
      int         ay[6] = '{400, 400, 408, 407, 400, 0};
      logic [2:0] ac[6] = '{3'b001, 3'b001, 3'b011, 3'b001, 3'b011, 3'b010};
      int         bx[5] = '{300, 307, 308, 364, 770};
      int         by[5] = '{400, 463, 403, 400, 63};
      logic [2:0] bc[5] = '{3'b100, 3'b100, 3'b001, 3'b011, 3'b010};
      logic [25:0] exp_w;
      latch3({10'd300, 10'd0, 10'd400}, 3'b110);
      for (int i = 0; i < 6; i++) begin
         in3 = px(ax[i], ay[i], 1'b1, 1'b0, 1'b0, 3'b011);
         step();
         exp_w = px(ax[i], ay[i], 1'b1, 1'b0, 1'b0, ac[i]);
         n_tests++;
         if (out3 !== exp_w) begin
            n_fail++;
            $display("FAIL horiz[%0d] (%0d,%0d): got %h, expected %h", i, ax[i], ay[i], out3, exp_w);
         end
      end
      latch3({10'd300, 10'd0, 10'd400}, 3'b111);
      for (int i = 0; i < 5; i++) begin
         in3 = px(bx[i], by[i], 1'b1, 1'b0, 1'b0, 3'b011);
         step();
         exp_w = px(bx[i], by[i], 1'b1, 1'b0, 1'b0, bc[i]);
         n_tests++;
         if (out3 !== exp_w) begin
            n_fail++;
            $display("FAIL priority[%0d] (%0d,%0d): got %h, expected %h", i, bx[i], by[i], out3, exp_w);
         end
      end
   endtask

   task automatic test_enable_blank_reset();
      latch2({10'd200, 10'd200}, 2'b01);
      in2 = px(770, 200, 1'b1, 1'b0, 1'b0, 3'b101);
      step();
      n_tests++;
      if (out2 !== px(770, 200, 1'b1, 1'b0, 1'b0, 3'b101)) begin
         n_fail++;
         $display("FAIL disabled_paddle: got %h, expected %h", out2, px(770, 200, 1'b1, 1'b0, 1'b0, 3'b101));
      end
      in2 = px(20, 200, 1'b1, 1'b0, 1'b0, 3'b000);
      step();
      n_tests++;
      if (out2 !== px(20, 200, 1'b1, 1'b0, 1'b0, 3'b111)) begin
         n_fail++;
         $display("FAIL enabled_paddle: got %h, expected %h", out2, px(20, 200, 1'b1, 1'b0, 1'b0, 3'b111));
      end
      in2 = px(20, 200, 1'b0, 1'b1, 1'b0, 3'b010);
      step();
      n_tests++;
      if (out2 !== px(20, 200, 1'b0, 1'b1, 1'b0, 3'b010)) begin
         n_fail++;
         $display("FAIL blanking: got %h, expected %h", out2, px(20, 200, 1'b0, 1'b1, 1'b0, 3'b010));
      end
      // reset together with a vsync edge: reset wins
      reset = 1'b1;
      in2   = px(20, 200, 1'b1, 1'b0, 1'b1, 3'b000);
      step();
      n_tests++;
      if (out2 !== 26'd0 || tick2 !== 1'b0) begin
         n_fail++;
         $display("FAIL midframe_reset: got out=%h tick=%b, expected out=0 tick=0", out2, tick2);
      end
      reset = 1'b0;
      in2   = px(20, 200, 1'b1, 1'b0, 1'b0, 3'b000);
      step();
      n_tests++;
      if (out2 !== px(20, 200, 1'b1, 1'b0, 1'b0, 3'b000) || tick2 !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_no_paddle: got out=%h tick=%b, expected out=%h tick=0",
                  out2, tick2, px(20, 200, 1'b1, 1'b0, 1'b0, 3'b000));
      end
   endtask

   initial begin
      reset = 1'b1;
      pos2  = '0;
      en2   = '0;
      pos3  = '0;
      en3   = '0;
      in2   = '0;
      in3   = '0;
      test_reset();
      test_no_vsync();
      test_basic();
      test_clamp();
      test_priority();
      test_enable_blank_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
